day_reset_ctrl: RTL and testbench
=================================

DAY_RESET_CTRL -- requirements
Module: day_reset_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: cycles the synchronized button must hold steady to register a new level.
REQ-002 The block SHALL have parameter LONG_PRESS_CYCLES, default 1024: debounced-press duration that classifies a press as long.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 15: maximum wait cycles for any ack edge.
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge clocked.
REQ-005 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port manual_reset, input, 1 bit: raw push-button, active-high, asynchronous to clk.
REQ-007 Port midnight, input, 1 bit: single-cycle pulse from the hours counter at 23:59:59 -> 00:00:00.
REQ-008 Port time_req, output, 1 bit: clear request to the time counters.
REQ-009 Port time_ack, input, 1 bit: four-phase ack from the time counters.
REQ-010 Port alarm_req, output, 1 bit: clear request to the alarm registers.
REQ-011 Port alarm_ack, input, 1 bit: four-phase ack from the alarm registers.
REQ-012 Port day_reseter, output, 1 bit: high while any clear sequence is in progress (state != IDLE).
REQ-013 Port fault, output, 1 bit: sticky flag, set on an ack timeout.

Function
REQ-014 manual_reset SHALL pass a 2-flop synchronizer, then a debouncer that updates its debounced level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-015 A short press SHALL be a debounced rise followed by a debounced fall before LONG_PRESS_CYCLES; the press event SHALL fire on the fall.
REQ-016 A long press SHALL fire exactly once, in the cycle the hold counter reaches LONG_PRESS_CYCLES; the later release SHALL generate no event.
REQ-017 The FSM SHALL have states IDLE, T_REQ, T_REL, A_REQ, A_REL.
REQ-018 IDLE SHALL move to T_REQ on midnight, a short press, a long press or a pending trigger. A long press or a pending long trigger SHALL also set the internal flag do_alarm.
REQ-019 time_req SHALL be high in T_REQ only; a trigger in cycle N SHALL give time_req=1 in cycle N+1.
REQ-020 T_REQ SHALL move to T_REL when time_ack=1. T_REL (req low) SHALL wait for time_ack=0, then go to A_REQ if do_alarm is set, else IDLE.
REQ-021 A_REQ and A_REL SHALL mirror T_REQ and T_REL using alarm_req and alarm_ack; A_REL SHALL exit to IDLE and clear do_alarm.
REQ-022 A per-state wait counter SHALL reset on each state entry. If it reaches ACK_TIMEOUT in any non-IDLE state, the FSM SHALL set fault, drop all reqs, clear do_alarm and return to IDLE.
REQ-023 A trigger arriving while state != IDLE SHALL set a pending flag, and a long press SHALL set pending_long; both SHALL be serviced at the next IDLE; multiple triggers SHALL collapse into one.
REQ-024 Simultaneous midnight and a press in IDLE SHALL start one sequence; do_alarm SHALL be set if the press is long.
REQ-025 time_req and alarm_req SHALL never be high in the same cycle.
REQ-026 fault SHALL clear only on reset_n; it SHALL NOT block later sequences.

Reset
REQ-027 On reset_n=0 the block SHALL asynchronously set state=IDLE, time_req=0, alarm_req=0, day_reseter=0, fault=0, and clear pending, pending_long, do_alarm, all counters and the synchronizer/debounced level (released).
REQ-028 Reset mid-sequence SHALL drop reqs immediately; no sequence SHALL resume after reset release.
REQ-029 Reset release SHALL be synchronized internally with a 2-flop deassertion synchronizer (assert async, release sync).

Structure
REQ-030 A shared package day_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-031 The debouncer SHALL be the sub-module btn_debounce (sync + debounce + short/long classification), instantiated once.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACK_TIMEOUT=8)
REQ-032 midnight pulse at cycle 10, ack responder delay 2 -> time_req high from 11 until ack, alarm_req never high, day_reseter low again after T_REL, fault=0.
REQ-033 Button high for 10 cycles -> one time-only sequence after release; a 2-cycle glitch -> no sequence.
REQ-034 Button held 40 cycles -> time then alarm sequence starting at the hold-count-20 cycle; the release causes nothing.
REQ-035 time_ack tied 0 -> fault=1 after 8 cycles in T_REQ, back to IDLE; a later midnight with a working ack completes normally with fault still 1.
REQ-036 midnight during A_REQ plus another midnight during A_REL -> exactly one further time-only sequence after IDLE.
REQ-037 reset_n low during T_REL -> time_req/alarm_req/day_reseter low immediately; after release, IDLE with no outputs until a new trigger.

Source files
------------

// File: rtl/day_pkg.sv
// Shared types and default constants for the day-reset controller.
package day_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T_REQ,
    T_REL,
    A_REQ,
    A_REL
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES   = 16;
  localparam int DEF_LONG_PRESS_CYCLES = 1024;
  localparam int DEF_ACK_TIMEOUT       = 15;

  // Bits needed for a counter that must hold the value n.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchronizer, debouncer and short/long press
// classification. Both press outputs are registered single-cycle pulses.
module btn_debounce
  import day_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic short_press,
  output logic long_press
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int HW = cnt_w(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          long_done;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      // NOTE: non-blocking so sync2 takes the pre-edge sync1, giving two real stages.
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level       <= 1'b0;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      long_done   <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      short_press <= 1'b0;
      long_press  <= 1'b0;

      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= sync2;
        db_cnt <= '0;
        // A release after a long press was already reported; stay silent.
        if (!sync2 && !long_done) short_press <= 1'b1;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end

      if (!level) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (!long_done) begin
        hold_cnt <= hold_cnt + HW'(1);
        if (hold_cnt == HOLD_LAST) begin
          long_done  <= 1'b1;
          long_press <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/day_reset_ctrl.sv
// Day reset sequencer: clears the time counters, and on a long press the alarm
// registers too, through four-phase req/ack handshakes with a timeout.
module day_reset_ctrl
  import day_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int ACK_TIMEOUT       = DEF_ACK_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic manual_reset,
  input  logic midnight,
  output logic time_req,
  input  logic time_ack,
  output logic alarm_req,
  input  logic alarm_ack,
  output logic day_reseter,
  output logic fault
);

  localparam int WW = cnt_w(ACK_TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);

  logic          rst_meta;
  logic          rst_n;
  logic          short_press;
  logic          long_press;
  logic          trigger;
  logic          ack_done;
  logic          do_alarm;
  logic          pending;
  logic          pending_long;
  logic [WW-1:0] wait_cnt;
  state_t        state;

  // Assert asynchronously, release on a clock edge so no flop sees a runt release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_btn (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (manual_reset),
    .short_press(short_press),
    .long_press (long_press)
  );

  assign trigger = midnight | short_press | long_press;

  always_comb begin
    // NOTE: default first so no latch is inferred for states without an ack.
    ack_done = 1'b0;
    case (state)
      T_REQ:   ack_done = time_ack;
      T_REL:   ack_done = !time_ack;
      A_REQ:   ack_done = alarm_ack;
      A_REL:   ack_done = !alarm_ack;
      default: ack_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      time_req     <= 1'b0;
      alarm_req    <= 1'b0;
      day_reseter  <= 1'b0;
      fault        <= 1'b0;
      do_alarm     <= 1'b0;
      pending      <= 1'b0;
      pending_long <= 1'b0;
      wait_cnt     <= '0;
    end else if (state == IDLE) begin
      if (trigger || pending) begin
        state        <= T_REQ;
        time_req     <= 1'b1;
        day_reseter  <= 1'b1;
        do_alarm     <= long_press | pending_long;
        pending      <= 1'b0;
        pending_long <= 1'b0;
        wait_cnt     <= '0;
      end
    end else begin
      // Triggers during a sequence collapse into one follow-up sequence.
      if (trigger) pending <= 1'b1;
      if (long_press) pending_long <= 1'b1;

      if (ack_done) begin
        wait_cnt <= '0;
        case (state)
          T_REQ: begin
            state    <= T_REL;
            time_req <= 1'b0;
          end
          T_REL: begin
            if (do_alarm) begin
              state     <= A_REQ;
              alarm_req <= 1'b1;
            end else begin
              state       <= IDLE;
              day_reseter <= 1'b0;
            end
          end
          A_REQ: begin
            state     <= A_REL;
            alarm_req <= 1'b0;
          end
          default: begin
            state       <= IDLE;
            day_reseter <= 1'b0;
            do_alarm    <= 1'b0;
          end
        endcase
      end else if (wait_cnt == WAIT_LAST) begin
        state       <= IDLE;
        fault       <= 1'b1;
        time_req    <= 1'b0;
        alarm_req   <= 1'b0;
        day_reseter <= 1'b0;
        do_alarm    <= 1'b0;
        wait_cnt    <= '0;
      end else begin
        wait_cnt <= wait_cnt + WW'(1);
      end
    end
  end

endmodule

// File: tb/tb_day_reset_ctrl.sv
// Scoreboard bench for day_reset_ctrl: expected sequences are queued by the
// stimulus and compared by a monitor each time day_reseter completes a sequence.
module tb_day_reset_ctrl;

  typedef struct {
    int   start;
    logic alarm;
    logic fault;
    int   tlen;
  } seq_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic manual_reset = 1'b0;
  logic midnight = 1'b0;
  logic time_ack = 1'b0;
  logic alarm_ack = 1'b0;
  logic time_req;
  logic alarm_req;
  logic day_reseter;
  logic fault;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  seq_t exp_q[$];
  bit   ta_en = 1'b1;
  int   tcnt = 0;
  int   acnt = 0;

  day_reset_ctrl #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20),
    .ACK_TIMEOUT      (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .manual_reset(manual_reset),
    .midnight    (midnight),
    .time_req    (time_req),
    .time_ack    (time_ack),
    .alarm_req   (alarm_req),
    .alarm_ack   (alarm_ack),
    .day_reseter (day_reseter),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic expect_seq(input int start, input logic alarm, input logic flt, input int tlen);
    seq_t s;
    s.start = start;
    s.alarm = alarm;
    s.fault = flt;
    s.tlen  = tlen;
    exp_q.push_back(s);
  endtask

  task automatic pulse_midnight(input int at);
    wait_cyc(at);
    midnight = 1'b1;
    @(negedge clk);
    midnight = 1'b0;
  endtask

  task automatic press(input int at, input int len);
    wait_cyc(at);
    manual_reset = 1'b1;
    wait_cyc(at + len);
    manual_reset = 1'b0;
  endtask

  // Ack responders: raise ack after req has been seen for two cycles, drop with req.
  always @(negedge clk) begin
    if (time_req && ta_en) begin
      tcnt++;
      if (tcnt >= 2) time_ack = 1'b1;
    end else if (!time_req) begin
      tcnt = 0;
      time_ack = 1'b0;
    end
    if (alarm_req) begin
      acnt++;
      if (acnt >= 2) alarm_ack = 1'b1;
    end else begin
      acnt = 0;
      alarm_ack = 1'b0;
    end
  end

  // Monitor: build one record per day_reseter pulse and compare against the queue.
  logic prev_dr = 1'b0;
  seq_t cur;
  always @(negedge clk) begin
    seq_t e;
    check("req_overlap", int'(time_req & alarm_req), 0);
    if (day_reseter) begin
      if (!prev_dr) begin
        cur.start = cyc;
        cur.alarm = 1'b0;
        cur.tlen  = 0;
      end
      if (time_req) cur.tlen++;
      if (alarm_req) cur.alarm = 1'b1;
    end else if (prev_dr) begin
      cur.fault = fault;
      check("seq_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seq_start", cur.start, e.start);
        check("seq_alarm", int'(cur.alarm), int'(e.alarm));
        check("seq_fault", int'(cur.fault), int'(e.fault));
        check("seq_tlen", cur.tlen, e.tlen);
      end
    end
    prev_dr = day_reseter;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_time_req", int'(time_req), 0);
    check("rst_alarm_req", int'(alarm_req), 0);
    check("rst_day_reseter", int'(day_reseter), 0);
    check("rst_fault", int'(fault), 0);
    reset_n = 1'b1;

    // Midnight: time-only sequence, req from the next cycle.
    expect_seq(11, 1'b0, 1'b0, 2);
    pulse_midnight(10);

    // Short press of 10 cycles fires on the debounced fall; 2-cycle glitch is ignored.
    expect_seq(47, 1'b0, 1'b0, 2);
    press(30, 10);
    press(60, 2);

    // Long press: fires when the hold count hits 20, release is silent.
    expect_seq(107, 1'b1, 1'b0, 2);
    press(80, 40);

    // Stuck time_ack: timeout after 8 req cycles, then a normal sequence with fault sticky.
    wait_cyc(135);
    ta_en = 1'b0;
    expect_seq(141, 1'b0, 1'b1, 8);
    pulse_midnight(140);
    wait_cyc(155);
    ta_en = 1'b1;
    expect_seq(161, 1'b0, 1'b1, 2);
    pulse_midnight(160);

    // Midnights during A_REQ and A_REL collapse into one time-only follow-up.
    expect_seq(207, 1'b1, 1'b1, 2);
    expect_seq(214, 1'b0, 1'b1, 2);
    wait_cyc(180);
    manual_reset = 1'b1;
    pulse_midnight(210);
    pulse_midnight(212);
    wait_cyc(220);
    manual_reset = 1'b0;

    // Reset during T_REL drops everything at once and clears fault.
    expect_seq(241, 1'b0, 1'b0, 2);
    pulse_midnight(240);
    wait_cyc(242);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort_time_req", int'(time_req), 0);
    check("abort_alarm_req", int'(alarm_req), 0);
    check("abort_day_reseter", int'(day_reseter), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_cyc(260);
    check("post_rst_time_req", int'(time_req), 0);
    check("post_rst_day_reseter", int'(day_reseter), 0);
    check("post_rst_fault", int'(fault), 0);

    expect_seq(266, 1'b0, 1'b0, 2);
    pulse_midnight(265);

    wait_cyc(290);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
